// File: rtl/cpu_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_fsm_pkg
// Description : Opcodes, instruction field ranges and state encodings shared
//               by the 16-bit core sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_control_fsm_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_LO = 4'h1;
    localparam logic [3:0] OP_ALU_HI = 4'h7;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_JMP    = 4'hA;
    localparam logic [3:0] OP_BEQZ   = 4'hB;
    localparam logic [3:0] OP_ILL_LO = 4'hC;
    localparam logic [3:0] OP_ILL_HI = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    localparam int TGT_W   = 12;

    localparam logic [2:0] C_ST_FETCH     = 3'd0;
    localparam logic [2:0] C_ST_DECODE    = 3'd1;
    localparam logic [2:0] C_ST_EXECUTE   = 3'd2;
    localparam logic [2:0] C_ST_MEM       = 3'd3;
    localparam logic [2:0] C_ST_WRITEBACK = 3'd4;
    localparam logic [2:0] C_ST_HALT      = 3'd5;

    typedef enum logic [2:0] {
        ST_FETCH     = C_ST_FETCH,
        ST_DECODE    = C_ST_DECODE,
        ST_EXECUTE   = C_ST_EXECUTE,
        ST_MEM       = C_ST_MEM,
        ST_WRITEBACK = C_ST_WRITEBACK,
        ST_HALT      = C_ST_HALT
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_control_fsm_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_fsm_pc_unit
// Description : Program counter with increment, absolute load and signed
//               8-bit relative add; asynchronous reset to RESET_PC.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_fsm_pc_unit #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_inc,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_val,
    input  logic            i_rel_add,
    input  logic [7:0]      i_offset,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_off;

    // Offset is sign-extended (or truncated) to PC_W so the add wraps naturally.
    generate
        if (PC_W > 8) begin : g_off_wide
            assign w_off = {{(PC_W-8){i_offset[7]}}, i_offset};
        end else if (PC_W == 8) begin : g_off_exact
            assign w_off = i_offset;
        end else begin : g_off_narrow
            assign w_off = i_offset[PC_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= PC_W'(RESET_PC);
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_rel_add) begin
            r_pc <= r_pc + w_off;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_fsm
// Description : Multi-cycle sequencer for the 16-bit core; owns pc and ir.
//               Define CTRL_MEM_WAIT_EN to add ram_ready wait states in MEM.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [15:0]     inst,
    input  logic            zero_flag,
`ifdef CTRL_MEM_WAIT_EN
    input  logic            ram_ready,
`endif
    output logic [PC_W-1:0] pc,
    output logic            rom_oeb,
    output logic [3:0]      opcode,
    output logic [3:0]      select1,
    output logic [3:0]      select2,
    output logic [3:0]      dest_sel,
    output logic            reg_we,
    output logic            wb_src,
    output logic            alu_en,
    output logic            ram_ce,
    output logic            ram_rw,
    output logic            halted,
    output logic            illegal
);

    state_t          r_state;
    state_t          w_next_state;
    logic [15:0]     r_ir;
    logic            r_illegal;
    logic [3:0]      w_op;
    logic            w_pc_inc;
    logic            w_pc_load;
    logic            w_pc_rel;
    logic            w_set_illegal;
    logic            w_mem_done;
    logic [PC_W-1:0] w_jmp_target;

    assign w_op = r_ir[OPC_MSB:OPC_LSB];

`ifdef CTRL_MEM_WAIT_EN
    assign w_mem_done = ram_ready;
`else
    assign w_mem_done = 1'b1;
`endif

    // Jump target field is 12 bits; wider pcs get it zero-extended.
    generate
        if (PC_W > TGT_W) begin : g_tgt_wide
            assign w_jmp_target = {{(PC_W-TGT_W){1'b0}}, r_ir[TGT_W-1:0]};
        end else begin : g_tgt_fit
            assign w_jmp_target = r_ir[PC_W-1:0];
        end
    endgenerate

    cpu_control_fsm_pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk        (clock),
        .rst        (reset),
        .i_inc      (w_pc_inc),
        .i_load     (w_pc_load),
        .i_load_val (w_jmp_target),
        .i_rel_add  (w_pc_rel),
        .i_offset   (r_ir[IMM_MSB:IMM_LSB]),
        .o_pc       (pc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_ir      <= 16'h0000;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_FETCH) begin
                r_ir <= inst;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_pc_inc      = 1'b0;
        w_pc_load     = 1'b0;
        w_pc_rel      = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_pc_inc     = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                w_next_state = (w_op == OP_HALT) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                w_next_state = ST_FETCH;
                if (w_op == OP_JMP) begin
                    w_pc_load = 1'b1;
                end else if (w_op == OP_BEQZ) begin
                    w_pc_rel = zero_flag;
                end else if ((w_op == OP_LOAD) || (w_op == OP_STORE)) begin
                    w_next_state = ST_MEM;
                end else if (is_alu_op(w_op)) begin
                    w_next_state = ST_WRITEBACK;
                end else if (is_illegal_op(w_op)) begin
                    w_set_illegal = 1'b1;
                end
            end
            ST_MEM: begin
                if (w_mem_done) begin
                    w_next_state = (w_op == OP_LOAD) ? ST_WRITEBACK : ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Moore output decode: strobes depend only on state and the latched ir.
    always_comb begin
        rom_oeb  = (r_state != ST_FETCH);
        opcode   = w_op;
        select1  = r_ir[RS1_MSB:RS1_LSB];
        select2  = r_ir[RS2_MSB:RS2_LSB];
        dest_sel = r_ir[RD_MSB:RD_LSB];
        alu_en   = (r_state == ST_EXECUTE) && is_alu_op(w_op);
        ram_ce   = (r_state == ST_MEM);
        ram_rw   = !((r_state == ST_MEM) && (w_op == OP_STORE));
        reg_we   = (r_state == ST_WRITEBACK);
        wb_src   = (r_state == ST_WRITEBACK) && (w_op == OP_LOAD);
        halted   = (r_state == ST_HALT);
        illegal  = r_illegal;
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_fsm
// Description : Directed self-checking bench for cpu_control_fsm (PC_W = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_fsm;
    import cpu_control_fsm_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] inst;
    logic        zero_flag;
    logic        ram_ready;
    logic [7:0]  pc;
    logic        rom_oeb;
    logic [3:0]  opcode;
    logic [3:0]  select1;
    logic [3:0]  select2;
    logic [3:0]  dest_sel;
    logic        reg_we;
    logic        wb_src;
    logic        alu_en;
    logic        ram_ce;
    logic        ram_rw;
    logic        halted;
    logic        illegal;

    logic [15:0] rom [0:255];
    int          vectors;
    int          miscompares;

    assign inst = rom[pc];

    cpu_control_fsm #(
        .PC_W     (8),
        .RESET_PC (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .inst      (inst),
        .zero_flag (zero_flag),
`ifdef CTRL_MEM_WAIT_EN
        .ram_ready (ram_ready),
`endif
        .pc        (pc),
        .rom_oeb   (rom_oeb),
        .opcode    (opcode),
        .select1   (select1),
        .select2   (select2),
        .dest_sel  (dest_sel),
        .reg_we    (reg_we),
        .wb_src    (wb_src),
        .alu_en    (alu_en),
        .ram_ce    (ram_ce),
        .ram_rw    (ram_rw),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1123;
        rom[1] = 16'h8240;
        rom[2] = 16'h9310;
        rom[3] = 16'hA0FF;
        rom[5] = 16'hB0FE;
        rom[6] = 16'hC000;
        rom[7] = 16'hF000;
        reset     = 1'b1;
        zero_flag = 1'b0;
        ram_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_pc", pc, 8'h00);
        check("rst_state", dut.r_state, ST_FETCH);
        check("rst_rom_oeb", rom_oeb, 1'b0);
        check("rst_strobes", {reg_we, alu_en, ram_ce, wb_src}, 4'b0000);
        check("rst_ram_rw", ram_rw, 1'b1);
        check("rst_halted_illegal", {halted, illegal}, 2'b00);
        check("rst_ir", dut.r_ir, 16'h0000);
        reset = 1'b0;

        // ALU op 1123
        check("alu_c1_state", dut.r_state, ST_FETCH);
        tick();
        check("alu_c2_state", dut.r_state, ST_DECODE);
        check("alu_c2_pc", pc, 8'h01);
        check("alu_c2_sel", {opcode, dest_sel, select1, select2}, 16'h1123);
        check("alu_c2_rom_oeb", rom_oeb, 1'b1);
        tick();
        check("alu_c3_state", dut.r_state, ST_EXECUTE);
        check("alu_c3_alu_en", alu_en, 1'b1);
        tick();
        check("alu_c4_state", dut.r_state, ST_WRITEBACK);
        check("alu_c4_we_src_ce", {reg_we, wb_src, ram_ce, alu_en}, 4'b1000);
        check("alu_c4_dest", dest_sel, 4'h1);
        tick();
        check("alu_back_fetch", {dut.r_state, pc}, {ST_FETCH, 8'h01});

        // LOAD 8240
        tick();
        tick();
        check("ld_c3_alu_en", {alu_en, ram_ce}, 2'b00);
        tick();
        check("ld_c4_mem", {ram_ce, ram_rw, reg_we}, 3'b110);
        tick();
        check("ld_c5_wb", {reg_we, wb_src, ram_ce, dest_sel}, {3'b110, 4'h2});
        tick();
        check("ld_back_fetch", {dut.r_state, pc}, {ST_FETCH, 8'h02});

        // STORE 9310
        tick();
        check("st_c2_we", reg_we, 1'b0);
        tick();
        check("st_c3_we", reg_we, 1'b0);
        tick();
        check("st_c4_mem", {ram_ce, ram_rw, reg_we}, 3'b100);
        tick();
        check("st_back_fetch", {dut.r_state, pc, reg_we}, {ST_FETCH, 8'h03, 1'b0});

        // JMP A0FF, then NOP at FF wraps to 00
        tick();
        tick();
        tick();
        check("jmp_pc", {dut.r_state, pc}, {ST_FETCH, 8'hFF});
        rom[0] = 16'hA005;
        tick();
        check("wrap_pc", pc, 8'h00);
        tick();
        tick();
        check("nop_latency", {dut.r_state, pc}, {ST_FETCH, 8'h00});

        // JMP 05, BEQZ B0FE taken then not taken
        tick();
        tick();
        tick();
        check("jmp5_pc", pc, 8'h05);
        zero_flag = 1'b1;
        rom[4]    = 16'hA005;
        tick();
        tick();
        tick();
        check("beqz_taken_pc", {dut.r_state, pc}, {ST_FETCH, 8'h04});
        tick();
        tick();
        tick();
        check("back_to_5", pc, 8'h05);
        zero_flag = 1'b0;
        check("pre_illegal", illegal, 1'b0);
        tick();
        tick();
        tick();
        check("beqz_not_taken_pc", {dut.r_state, pc}, {ST_FETCH, 8'h06});

        // Illegal C000 then HALT
        tick();
        tick();
        tick();
        check("illegal_set", {illegal, pc}, {1'b1, 8'h07});
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("halt_outputs", {halted, rom_oeb, reg_we, alu_en, ram_ce, wb_src, ram_rw},
                  7'b1100001);
            check("halt_pc", pc, 8'h08);
            tick();
        end
        check("illegal_sticky", illegal, 1'b1);

        // Reset exits HALT, then reset aborts a LOAD in MEM
        rom[0] = 16'h8240;
        reset  = 1'b1;
        tick();
        check("rst2_clear", {halted, illegal, pc}, {2'b00, 8'h00});
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("abort_in_mem", {dut.r_state, ram_ce}, {ST_MEM, 1'b1});
        #2 reset = 1'b1;
        #1;
        check("abort_ram_ce", {ram_ce, reg_we}, 2'b00);
        check("abort_pc", {dut.r_state, pc}, {ST_FETCH, 8'h00});
        tick();
        reset = 1'b0;
        tick();
        check("abort_restart", {dut.r_state, pc, reg_we}, {ST_DECODE, 8'h01, 1'b0});

`ifdef CTRL_MEM_WAIT_EN
        // Wait states: ram_ready low for 3 sampled edges holds MEM 4 cycles
        ram_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("wait_mem_hold", {dut.r_state, ram_ce, ram_rw, reg_we}, {ST_MEM, 3'b110});
            if (i == 3) ram_ready = 1'b1;
            tick();
        end
        check("wait_exit_wb", {dut.r_state, reg_we, wb_src}, {ST_WRITEBACK, 2'b11});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
